// File: rtl/cpu_arb_pkg.sv
// cpu_arb_pkg: shared states and port indices for the cache-to-memory bus arbiter
package cpu_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} arb_state_t;
  localparam int PORT_ICACHE = 0;
  localparam int PORT_DCACHE = 1;
endpackage

// File: rtl/cpu_rr_picker.sv
// cpu_rr_picker: combinational 2-way round-robin select; on a tie the port not served last wins
module cpu_rr_picker
  import cpu_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt,
  output logic       valid
);
  always_comb begin
    gnt   = &req ? (2'b01 << (last_gnt ? PORT_ICACHE : PORT_DCACHE)) : req;
    valid = |req;
  end
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one memory bus between icache (port 0) and dcache (port 1),
// one full issue/accept/response transaction at a time.
module cpu_mem_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_write,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][LINE_WIDTH-1:0] req_data,
  output logic [1:0]                 gnt,
  output logic [1:0]                 resp_valid,
  output logic [LINE_WIDTH-1:0]      resp_data,
  output logic                       mem_req_valid,
  output logic                       mem_req_write,
  output logic [ADDR_WIDTH-1:0]      mem_req_addr,
  output logic [LINE_WIDTH-1:0]      mem_req_data,
  input  logic                       mem_available,
  input  logic                       mem_resp_valid,
  input  logic [LINE_WIDTH-1:0]      mem_resp_data,
  output logic                       timeout_err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  arb_state_t state, state_nx;
  logic owner, last_gnt, pick_valid, wd_hit;
  logic [1:0] pick;
  logic [CW-1:0] cnt;
  cpu_rr_picker u_picker (
    .req      (req_valid),
    .last_gnt (last_gnt),
    .gnt      (pick),
    .valid    (pick_valid)
  );
  // cnt is 0 in the first WAIT_RESP cycle, so the abort fires in the TIMEOUT-th cycle there
  assign wd_hit    = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  assign resp_data = mem_resp_data;
  always_comb begin
    state_nx    = state;
    resp_valid  = '0;
    timeout_err = 1'b0;
    unique case (state)
      IDLE:    state_nx = pick_valid ? ISSUE : IDLE;
      ISSUE:   state_nx = mem_available ? WAIT_RESP : (req_valid[owner] ? ISSUE : IDLE);
      WAIT_RESP: begin
        resp_valid[owner] = mem_resp_valid;
        timeout_err       = !mem_resp_valid && wd_hit;
        state_nx          = (mem_resp_valid || wd_hit) ? IDLE : WAIT_RESP;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  always_ff @(posedge clock) begin
    if (reset) begin
      owner         <= 1'b0;
      last_gnt      <= 1'b1;
      gnt           <= '0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      cnt           <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        owner         <= pick[PORT_DCACHE];
        gnt           <= pick;
        mem_req_valid <= 1'b1;
        mem_req_write <= req_write[pick[PORT_DCACHE]];
        mem_req_addr  <= req_addr[pick[PORT_DCACHE]];
        mem_req_data  <= req_data[pick[PORT_DCACHE]];
      end
      if (state == ISSUE && state_nx != ISSUE) mem_req_valid <= 1'b0;
      if (state != IDLE && state_nx == IDLE) gnt <= '0;
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT_RESP && cnt != '1) cnt <= cnt + 1'b1;
      // an abort in ISSUE or a timeout leaves the round-robin pointer alone
      if (|resp_valid) last_gnt <= owner;
    end
  end
endmodule
